// File: rtl/mem_access_unit.sv
// MAR/MDR memory-access unit: latches address/data from the datapath bus and
// runs fixed-length read/write strobe cycles against an asynchronous SRAM.
module mem_access_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_STATES = 2,
  localparam int LANES      = DATA_W / 8,
  localparam int LANE_BITS  = $clog2(LANES)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_mar,
  input  logic              load_mdr,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic              byte_mode,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              CE_n,
  output logic              OE_n,
  output logic              WE_n,
  output logic [LANES-1:0]  BE_n,
  output logic              mem_resp,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   mdr;
  logic [3:0]          cnt;
  logic                byte_q;
  logic [LANE_BITS-1:0] lane;
  logic [7:0]          rd_byte;
  logic [DATA_W-1:0]   rd_value;
  logic [LANES-1:0]    lane_sel;
  logic                start;

  assign lane     = mar[LANE_BITS-1:0];
  assign rd_byte  = mem_rdata[lane*8 +: 8];
  assign rd_value = byte_q ? DATA_W'(rd_byte) : mem_rdata;
  assign lane_sel = LANES'(1) << lane;
  assign start    = mem_rd_req ^ mem_wr_req;

  assign ADDR      = mar;
  assign mdr_out   = mdr;
  assign mem_wdata = byte_q ? {LANES{mdr[7:0]}} : mdr;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_rd_req && !mem_wr_req)      state_next = READ;
        else if (mem_wr_req && !mem_rd_req) state_next = WRITE;
      end
      READ:    if (cnt == '0) state_next = DONE;
      WRITE:   if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    CE_n     = 1'b1;
    OE_n     = 1'b1;
    WE_n     = 1'b1;
    BE_n     = '1;
    mem_resp = 1'b0;
    busy     = (state != IDLE);
    case (state)
      READ: begin
        CE_n = 1'b0;
        OE_n = 1'b0;
        BE_n = '0;
      end
      WRITE: begin
        CE_n = 1'b0;
        WE_n = 1'b0;
        BE_n = byte_q ? ~lane_sel : '0;
      end
      DONE:    mem_resp = 1'b1;
      default: ;
    endcase
  end

  // Loads precede the request in the same IDLE cycle, so the access sees new MAR/MDR.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mar    <= '0;
      mdr    <= '0;
      cnt    <= '0;
      byte_q <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_mar) mar <= ADDR_W'(bus_in);
          if (load_mdr) mdr <= bus_in;
          if (start) begin
            cnt    <= 4'(WAIT_STATES - 1);
            byte_q <= byte_mode;
          end
          if (mem_rd_req && mem_wr_req) err <= 1'b1;
        end
        READ: begin
          if (cnt == '0) mdr <= rd_value;
          else           cnt <= cnt - 4'd1;
        end
        WRITE: begin
          if (cnt != '0) cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit; three instances with
// wait-state counts 1, 2 and 15 share one stimulus stream.
module tb_mem_access_unit;

  localparam int N = 3;

  logic        Clk = 1'b0;
  logic        Reset, load_mar, load_mdr, mem_rd_req, mem_wr_req, byte_mode;
  logic [15:0] bus_in, mem_rdata;

  logic [15:0] mdr_out   [N];
  logic [19:0] addr      [N];
  logic [15:0] mem_wdata [N];
  logic        ce_n [N], oe_n [N], we_n [N];
  logic [1:0]  be_n [N];
  logic        resp [N], busy [N], err [N];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_access_unit #(
      .DATA_W(16), .ADDR_W(20),
      .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 2 : 15)
    ) dut (
      .Clk(Clk), .Reset(Reset), .load_mar(load_mar), .load_mdr(load_mdr),
      .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .byte_mode(byte_mode),
      .bus_in(bus_in), .mdr_out(mdr_out[g]), .ADDR(addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata),
      .CE_n(ce_n[g]), .OE_n(oe_n[g]), .WE_n(we_n[g]), .BE_n(be_n[g]),
      .mem_resp(resp[g]), .busy(busy[g]), .err(err[g])
    );
  end

  int tests = 0;
  int fails = 0;

  logic [19:0] mar_m;
  logic [15:0] mdr_m;
  logic        err_m;

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic quiet_inputs;
    load_mar   = 1'b0;
    load_mdr   = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    byte_mode  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s ce_n i%0d", tag, i), ce_n[i], 1'b1);
      check($sformatf("%s oe_n i%0d", tag, i), oe_n[i], 1'b1);
      check($sformatf("%s we_n i%0d", tag, i), we_n[i], 1'b1);
      check($sformatf("%s be_n i%0d", tag, i), be_n[i], 2'b11);
      check($sformatf("%s resp i%0d", tag, i), resp[i], 1'b0);
      check($sformatf("%s busy i%0d", tag, i), busy[i], 1'b0);
      check($sformatf("%s addr i%0d", tag, i), addr[i], mar_m);
      check($sformatf("%s mdr i%0d", tag, i), mdr_out[i], mdr_m);
      check($sformatf("%s err i%0d", tag, i), err[i], err_m);
    end
  endtask

  task automatic do_reset(input int cycles);
    Reset = 1'b1;
    quiet_inputs();
    repeat (cycles) tick();
    Reset = 1'b0;
    mar_m = '0;
    mdr_m = '0;
    err_m = 1'b0;
    check_idle("reset");
  endtask

  task automatic idle_cycle(input bit lm, input bit ld, input bit collide, input logic [15:0] bus);
    load_mar   = lm;
    load_mdr   = ld;
    mem_rd_req = collide;
    mem_wr_req = collide;
    bus_in     = bus;
    tick();
    quiet_inputs();
    if (lm) mar_m = {4'h0, bus};
    if (ld) mdr_m = bus;
    if (collide) err_m = 1'b1;
    check_idle("idle");
  endtask

  // One access started from IDLE; 17 cycles cover the slowest instance plus a spare.
  task automatic do_access(input bit wr, input bit bm, input bit lm, input bit ld,
                           input logic [15:0] bus, input logic [15:0] rdata, input bit garbage);
    logic [15:0] old_mdr, new_mdr, exp_wdata;
    logic [1:0]  exp_be_wr;
    int          lane, w;
    bit          active;
    load_mar   = lm;
    load_mdr   = ld;
    bus_in     = bus;
    mem_rd_req = !wr;
    mem_wr_req = wr;
    byte_mode  = bm;
    mem_rdata  = rdata;
    if (lm) mar_m = {4'h0, bus};
    if (ld) mdr_m = bus;
    old_mdr   = mdr_m;
    lane      = int'(mar_m % 2);
    if (wr)      new_mdr = old_mdr;
    else if (bm) new_mdr = (rdata >> (8 * lane)) & 16'h00FF;
    else         new_mdr = rdata;
    exp_wdata = bm ? {old_mdr[7:0], old_mdr[7:0]} : old_mdr;
    exp_be_wr = bm ? ((lane == 1) ? 2'b01 : 2'b10) : 2'b00;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (garbage && k <= 2) begin
        load_mar   = 1'b1;
        load_mdr   = 1'b1;
        bus_in     = (k == 1) ? 16'h1111 : 16'($urandom);
        mem_rd_req = 1'($urandom);
        mem_wr_req = 1'($urandom);
        byte_mode  = 1'($urandom);
      end else begin
        quiet_inputs();
      end
      for (int i = 0; i < N; i++) begin
        w = ws_of(i);
        active = (k <= w);
        check($sformatf("acc ce_n i%0d k%0d", i, k), ce_n[i], !active);
        check($sformatf("acc oe_n i%0d k%0d", i, k), oe_n[i], wr ? 1'b1 : !active);
        check($sformatf("acc we_n i%0d k%0d", i, k), we_n[i], wr ? !active : 1'b1);
        check($sformatf("acc be_n i%0d k%0d", i, k), be_n[i],
              active ? (wr ? exp_be_wr : 2'b00) : 2'b11);
        check($sformatf("acc resp i%0d k%0d", i, k), resp[i], k == w + 1);
        check($sformatf("acc busy i%0d k%0d", i, k), busy[i], k <= w + 1);
        check($sformatf("acc addr i%0d k%0d", i, k), addr[i], mar_m);
        check($sformatf("acc mdr i%0d k%0d", i, k), mdr_out[i], active ? old_mdr : new_mdr);
        check($sformatf("acc err i%0d k%0d", i, k), err[i], err_m);
        if (wr && k <= w + 1)
          check($sformatf("acc wdata i%0d k%0d", i, k), mem_wdata[i], exp_wdata);
      end
    end
    mdr_m = new_mdr;
  endtask

  task automatic reset_mid_write;
    idle_cycle(1'b1, 1'b1, 1'b0, 16'h2345);
    mem_wr_req = 1'b1;
    tick();
    mem_wr_req = 1'b0;
    for (int i = 0; i < N; i++)
      check($sformatf("midwr we_n low i%0d", i), we_n[i], 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    mar_m = '0;
    mdr_m = '0;
    err_m = 1'b0;
    check_idle("midwr after reset");
    repeat (17) begin
      tick();
      check_idle("midwr quiet");
    end
  endtask

  initial begin
    Reset     = 1'b1;
    bus_in    = '0;
    mem_rdata = '0;
    quiet_inputs();
    do_reset(2);

    idle_cycle(1'b1, 1'b0, 1'b0, 16'h3000);
    do_access(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b0);
    idle_cycle(1'b1, 1'b0, 1'b0, 16'h3001);
    idle_cycle(1'b0, 1'b1, 1'b0, 16'h00A5);
    do_access(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    idle_cycle(1'b1, 1'b0, 1'b0, 16'h3000);
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h12F4, 1'b0);
    idle_cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    idle_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    do_access(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b1);
    do_access(1'b1, 1'b0, 1'b1, 1'b1, 16'hC0DE, 16'h0000, 1'b0);
    reset_mid_write();

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3))
        idle_cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0), 16'($urandom));
      do_access(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                16'($urandom), 16'($urandom), 1'($urandom));
    end

    do_reset(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
